load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the core's execute stage and the data memory port.
- Accepts one load/store request at a time via valid/ready.
- Drives a word-addressed memory bus: req/gnt for the request phase, rvalid for read data.
- Steers byte lanes, generates byte enables, sign/zero-extends load data, and reports misalignment, illegal funct3 and bus timeout as a one-cycle response pulse.

Parameters:
- XLEN, 32, data width; only 32 is supported.
- ADDR_W, 32, byte-address width.
- TIMEOUT_CYCLES, 16, maximum cycles spent in ISSUE+WAIT_R before a timeout error; must be >= 2.

Ports:
- i_clk  in  1  core clock
- i_rstn  in  1  asynchronous active-low reset
- i_req_valid  in  1  request valid from execute stage
- o_req_ready  out  1  unit can accept a request (IDLE and i_rstn high)
- i_req_we  in  1  1 = store, 0 = load
- i_req_funct3  in  3  RV32I funct3 (LB=0 LH=1 LW=2 LBU=4 LHU=5; SB=0 SH=1 SW=2)
- i_req_addr  in  ADDR_W  byte address
- i_req_wdata  in  XLEN  store data (rs2)
- o_mem_req  out  1  memory request
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- o_mem_be  out  4  byte enables
- o_mem_wdata  out  XLEN  lane-replicated store data
- i_mem_gnt  in  1  request accepted by memory
- i_mem_rvalid  in  1  read data valid
- i_mem_rdata  in  XLEN  raw read word
- o_rsp_valid  out  1  one-cycle completion pulse
- o_rsp_rdata  out  XLEN  extended load data (0 for stores/errors)
- o_rsp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout

Behaviour:
- Reset (async, i_rstn=0):
  - state=IDLE, timeout counter=0, captured request cleared.
  - All outputs 0, including o_req_ready.
  - Reset mid-transaction abandons it; no o_rsp_valid is produced.
- States: IDLE, ISSUE, WAIT_R, RESP.
- IDLE: o_req_ready=1. On i_req_valid, capture we/funct3/addr/wdata.
  - Illegal funct3 (load 3,6,7; store >2): go to RESP, err=10, no memory access.
  - Else misaligned (half: addr[0]!=0; word: addr[1:0]!=0): go to RESP, err=01, no memory access.
  - Illegal funct3 takes priority over misalignment.
  - Otherwise go to ISSUE and clear the counter.
- ISSUE:
  - o_mem_req=1; addr/we/be/wdata driven from registered values and held stable until i_mem_gnt.
  - On gnt: a store goes to RESP with err=00; a load goes to WAIT_R.
  - o_mem_req drops in the cycle after gnt.
- WAIT_R:
  - On i_mem_rvalid, latch the extended data and go to RESP.
  - An i_mem_rvalid arriving in the gnt cycle is ignored; memory returns data at least one cycle after gnt.
- Timeout:
  - The counter increments every cycle in ISSUE and WAIT_R.
  - If it reaches TIMEOUT_CYCLES-1 with no gnt (ISSUE) or no rvalid (WAIT_R), go to RESP with err=11 and rdata=0.
  - If gnt/rvalid arrives in that same cycle, it wins.
- RESP: o_rsp_valid=1 for exactly one cycle, then IDLE. o_rsp_rdata and o_rsp_err are valid only while o_rsp_valid=1 and are 0 otherwise.
- Latency with zero-wait memory, request accepted at edge N:
  - load o_rsp_valid is high in cycle N+3;
  - store in cycle N+2;
  - error in cycle N+1.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}.
  - SW: be=4'b1111.
- Loads drive be=4'b1111 and we=0.
- Load extraction:
  - shifted = rdata >> (8*addr[1:0]).
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.

Decomposition:
- Shared package lsu_pkg holds:
  - lsu_state_t (IDLE, ISSUE, WAIT_R, RESP);
  - lsu_err_t (ERR_NONE, ERR_MISALIGN, ERR_FUNCT3, ERR_TIMEOUT);
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
- One combinational sub-module, lsu_align, covers byte-enable/wdata steering for stores and shift/extend for loads. It keeps the FSM in load_store_unit free of lane logic.

Test Plan:
- LB at addr 0x103, memory word 0x80FF_1234, zero-wait -> be=1111, o_mem_addr=0x100, rsp_rdata=0xFFFF_FF80, err=00, rsp_valid at N+3.
- SH at addr 0x202, wdata 0x0000_ABCD, gnt delayed 2 cycles -> req held stable 3 cycles, be=1100, wdata=0xABCD_ABCD, rsp_valid 1 cycle after gnt, err=00.
- LW at addr 0x105 -> no o_mem_req, rsp_valid at N+1, err=01. Load with funct3=3 -> err=10, no o_mem_req.
- LHU at 0x100, gnt given, rvalid never asserted, TIMEOUT_CYCLES=16 -> rsp_valid with err=11, rdata=0 exactly 16 cycles after entering ISSUE.
- Assert i_rstn=0 while in WAIT_R -> all outputs 0 immediately; o_rsp_valid never pulses; a subsequent LW of 0xDEAD_BEEF completes normally.
- Back-to-back: i_req_valid held high for SB then LBU at the same address 0x10 -> second request accepted only after RESP; LBU returns 0x0000_00xx matching the stored byte.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Holds the FSM state, the error codes and the RV32I funct3 decode.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_R,
    RESP
  } lsu_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_FUNCT3   = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } lsu_err_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  function automatic logic f3_illegal(
    input logic       we,
    input logic [2:0] f3
  );
    if (we) return f3 > F3_W;
    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

  // Size lives in f3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    return ((f3[1:0] == 2'b01) && a[0])
        || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and shift/extend for loads.
// Purely combinational; the FSM never touches lane logic.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata_lane,
  output logic [XLEN-1:0] rdata_ext
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    if (we) begin
      unique case (funct3[1:0])
        2'b00: begin
          be         = 4'b0001 << addr_lo;
          wdata_lane = {4{wdata[7:0]}};
        end
        2'b01: begin
          be         = 4'b0011 << {addr_lo[1], 1'b0};
          wdata_lane = {2{wdata[15:0]}};
        end
        default: begin
          be         = 4'b1111;
          wdata_lane = wdata;
        end
      endcase
    end
  end

  always_comb begin
    shifted   = rdata >> {addr_lo, 3'b000};
    rdata_ext = shifted;
    unique case (funct3)
      F3_B:  rdata_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_H:  rdata_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_BU: rdata_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_HU: rdata_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: execute-stage request in, word-addressed
// req/gnt/rvalid bus out, one-cycle response pulse back.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [XLEN-1:0]   i_req_wdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [XLEN-1:0]   o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [XLEN-1:0]   i_mem_rdata,
  output logic              o_rsp_valid,
  output logic [XLEN-1:0]   o_rsp_rdata,
  output logic [1:0]        o_rsp_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_t        state_q, state_d;
  lsu_err_t          err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  logic [3:0]      be;
  logic [XLEN-1:0] wdata_lane;
  logic [XLEN-1:0] rdata_ext;

  lsu_align #(.XLEN(XLEN)) u_align (
    .we         (we_q),
    .funct3     (f3_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (i_mem_rdata),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          we_d    = i_req_we;
          f3_d    = i_req_funct3;
          addr_d  = i_req_addr;
          wdata_d = i_req_wdata;
          rdata_d = '0;
          if (f3_illegal(i_req_we, i_req_funct3)) begin
            state_d = RESP;
            err_d   = ERR_FUNCT3;
          end else if (misaligned(i_req_funct3, i_req_addr[1:0])) begin
            state_d = RESP;
            err_d   = ERR_MISALIGN;
          end else begin
            state_d = ISSUE;
            err_d   = ERR_NONE;
            cnt_d   = '0;
          end
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + CW'(1);
        if (i_mem_gnt) begin
          state_d = we_q ? RESP : WAIT_R;
        end else if (cnt_q == CNT_MAX) begin
          state_d = RESP;
          err_d   = ERR_TIMEOUT;
        end
      end
      WAIT_R: begin
        cnt_d = cnt_q + CW'(1);
        // rvalid beats the timeout when both land together.
        if (i_mem_rvalid) begin
          state_d = RESP;
          rdata_d = rdata_ext;
        end else if (cnt_q == CNT_MAX) begin
          state_d = RESP;
          err_d   = ERR_TIMEOUT;
        end
      end
      RESP: begin
        state_d = IDLE;
        err_d   = ERR_NONE;
        rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      err_q   <= ERR_NONE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  logic issue;
  assign issue = (state_q == ISSUE);

  assign o_req_ready = (state_q == IDLE) && i_rstn;
  assign o_mem_req   = issue;
  assign o_mem_we    = issue && we_q;
  assign o_mem_addr  = issue ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign o_mem_be    = issue ? be : 4'b0000;
  assign o_mem_wdata = (issue && we_q) ? wdata_lane : '0;
  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a scoreboard of
// expected responses and a small behavioural memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_f3 = 3'd0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;

  load_store_unit #(
    .XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_funct3 (req_f3),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_be     (mem_be),
    .o_mem_wdata  (mem_wdata),
    .i_mem_gnt    (mem_gnt),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
  } exp_t;
  exp_t sb[$];

  int rsp_cnt = 0;
  int rsp_cyc = 0;
  bit prev_rsp = 1'b0;

  logic [31:0] mem [logic [31:0]];
  int gnt_delay = 0;
  bit rvalid_en = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor / scoreboard consumer
  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      chk("rsp_one_cycle", {31'b0, prev_rsp}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {30'b0, rsp_err}, {30'b0, e.err});
      end
    end
    prev_rsp = rsp_valid;
  end

  // Memory responder
  int  wait_cnt = 0;
  bit  pending_rd = 1'b0;
  logic [31:0] rd_word = '0;
  initial begin
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (!rstn) begin
        pending_rd = 1'b0;
        wait_cnt = 0;
      end else begin
        if (pending_rd) begin
          if (rvalid_en) begin
            mem_rvalid = 1'b1;
            mem_rdata = rd_word;
          end
          pending_rd = 1'b0;
        end
        if (mem_req) begin
          if (wait_cnt < gnt_delay) begin
            wait_cnt++;
          end else begin
            logic [31:0] w;
            mem_gnt = 1'b1;
            wait_cnt = 0;
            w = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
            if (mem_we) begin
              for (int b = 0; b < 4; b++)
                if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
              mem[mem_addr] = w;
            end else begin
              pending_rd = 1'b1;
              rd_word = w;
            end
          end
        end else begin
          wait_cnt = 0;
        end
      end
    end
  end

  task automatic run_req(
    input string       tag,
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [31:0] exp_rdata,
    input logic [1:0]  exp_err,
    input int          exp_lat,
    input int          exp_reqc,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_wdata
  );
    int acc, n0, reqc, k;
    reqc = 0;
    req_we = we;
    req_f3 = f3;
    req_addr = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    sb.push_back('{exp_rdata, exp_err});
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk); #1; k++;
    end
    if (k >= 50) chk({tag, "_accept_bound"}, 32'(k), 32'd0);
    acc = cyc + 1;
    n0 = rsp_cnt;
    @(negedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (rsp_cnt == n0 && k < 60) begin
      if (mem_req) begin
        reqc++;
        chk({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
        chk({tag, "_we"}, {31'b0, mem_we}, {31'b0, we});
        chk({tag, "_be"}, {28'b0, mem_be}, {28'b0, exp_be});
        if (we) chk({tag, "_wdata"}, mem_wdata, exp_wdata);
      end
      @(negedge clk); #1; k++;
    end
    if (k >= 60) chk({tag, "_rsp_bound"}, 32'(k), 32'd0);
    chk({tag, "_lat"}, 32'(rsp_cyc - acc), 32'(exp_lat));
    chk({tag, "_reqc"}, 32'(reqc), 32'(exp_reqc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2, n0, k;
    mem[32'h100] = 32'h80FF_1234;
    mem[32'h300] = 32'h1357_9BDF;
    mem[32'h400] = 32'hDEAD_BEEF;
    mem[32'h10]  = 32'h1122_3344;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    rstn = 1'b1;
    @(negedge clk); #1;
    chk("idle_ready", {31'b0, req_ready}, 32'd1);

    run_req("lb", 0, 3'd0, 32'h103, 0, 32'hFFFF_FF80, 2'b00,
            2, 1, 4'b1111, 0);
    gnt_delay = 2;
    run_req("sh", 1, 3'd1, 32'h202, 32'h0000_ABCD, 0, 2'b00,
            3, 3, 4'b1100, 32'hABCD_ABCD);
    gnt_delay = 0;
    run_req("lw_mis", 0, 3'd2, 32'h105, 0, 0, 2'b01, 0, 0, 4'b0, 0);
    run_req("ld_f3_3", 0, 3'd3, 32'h100, 0, 0, 2'b10, 0, 0, 4'b0, 0);
    run_req("ld_f3_prio", 0, 3'd6, 32'h101, 0, 0, 2'b10, 0, 0, 4'b0, 0);
    run_req("st_f3_3", 1, 3'd3, 32'h100, 0, 0, 2'b10, 0, 0, 4'b0, 0);
    run_req("sh_mis", 1, 3'd1, 32'h101, 0, 0, 2'b01, 0, 0, 4'b0, 0);
    run_req("lh", 0, 3'd1, 32'h102, 0, 32'hFFFF_80FF, 2'b00,
            2, 1, 4'b1111, 0);
    run_req("sb", 1, 3'd0, 32'h101, 32'h0000_0077, 0, 2'b00,
            1, 1, 4'b0010, 32'h7777_7777);
    run_req("lbu", 0, 3'd4, 32'h101, 0, 32'h0000_0077, 2'b00,
            2, 1, 4'b1111, 0);
    run_req("sw", 1, 3'd2, 32'h204, 32'h1234_5678, 0, 2'b00,
            1, 1, 4'b1111, 32'h1234_5678);
    run_req("lw_rd", 0, 3'd2, 32'h204, 0, 32'h1234_5678, 2'b00,
            2, 1, 4'b1111, 0);

    // Read timeout: gnt at once, rvalid never
    rvalid_en = 1'b0;
    run_req("lhu_to", 0, 3'd5, 32'h100, 0, 0, 2'b11,
            16, 1, 4'b1111, 0);
    rvalid_en = 1'b1;
    // Grant timeout, then gnt landing in the final cycle
    gnt_delay = 40;
    run_req("sw_to", 1, 3'd2, 32'h208, 32'hCAFE_F00D, 0, 2'b11,
            16, 16, 4'b1111, 32'hCAFE_F00D);
    gnt_delay = 15;
    run_req("sw_last", 1, 3'd2, 32'h208, 32'hCAFE_F00D, 0, 2'b00,
            16, 16, 4'b1111, 32'hCAFE_F00D);
    gnt_delay = 0;

    // Reset while in WAIT_R
    rvalid_en = 1'b0;
    req_we = 1'b0; req_f3 = 3'd2;
    req_addr = 32'h300; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk); #1; k++;
    end
    @(negedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); #1;
    n0 = rsp_cnt;
    rstn = 1'b0;
    #1;
    chk("rstw_ready", {31'b0, req_ready}, 32'd0);
    chk("rstw_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rstw_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rstw_rsp_err", {30'b0, rsp_err}, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    rstn = 1'b1;
    rvalid_en = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("rstw_no_rsp", 32'(rsp_cnt - n0), 32'd0);
    run_req("lw_after_rst", 0, 3'd2, 32'h400, 0, 32'hDEAD_BEEF, 2'b00,
            2, 1, 4'b1111, 0);

    // Back-to-back: SB then LBU with valid held high
    req_we = 1'b1; req_f3 = 3'd0;
    req_addr = 32'h10; req_wdata = 32'h0000_00A5;
    req_valid = 1'b1;
    sb.push_back('{32'h0, 2'b00});
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk); #1; k++;
    end
    acc1 = cyc + 1;
    n0 = rsp_cnt;
    @(negedge clk); #1;
    req_we = 1'b0; req_f3 = 3'd4;
    sb.push_back('{32'h0000_00A5, 2'b00});
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk); #1; k++;
    end
    acc2 = cyc + 1;
    chk("b2b_first_done", 32'(rsp_cnt - n0), 32'd1);
    chk("b2b_gap", 32'(acc2 - acc1), 32'd3);
    @(negedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (rsp_cnt - n0 < 2 && k < 30) begin
      @(negedge clk); #1; k++;
    end
    chk("b2b_rsp_count", 32'(rsp_cnt - n0), 32'd2);
    chk("b2b_lat", 32'(rsp_cyc - acc2), 32'd2);
    chk("b2b_mem_word", mem[32'h10], 32'h1122_33A5);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
